timer_unit: RTL and testbench
=============================

// Module: timer_unit
// PURPOSE
//  GameBoy DIV/TIMA/TMA/TAC timer. Memory-mapped at FF04-FF07; the address decoder drives sel/addr upstream.
//  Produces the timer interrupt request that the datapath's interrupt logic consumes (IF bit 2).
//  Runs on the datapath clock (one clk = one T-cycle, 4.194304 MHz) and sits beside the datapath on its I/O bus.
// PARAMETERS
//  SYS_W      16  width of internal system counter; DIV = sys_cnt[SYS_W-1 -: 8]
//  OVF_DELAY  4   cycles TIMA reads 8'h00 after overflow before the TMA reload and IRQ
// PORTS
//  clk        in   1  system clock, rising-edge
//  rst        in   1  asynchronous, active-low reset
//  sel        in   1  bus access targets FF04-FF07 this cycle
//  addr       in   2  register offset: 0 = DIV, 1 = TIMA, 2 = TMA, 3 = TAC
//  we         in   1  write strobe (qualified by sel), one cycle per write
//  wdata      in   8  write data
//  rdata      out  8  read data, combinational from addr; 8'hFF when sel = 0
//  timer_irq  out  1  one-cycle pulse requesting the timer interrupt
// BEHAVIOUR
//  Reset (rst = 0, async): sys_cnt = 0, TIMA = 0, TMA = 0, TAC = 3'b000, state = RUN, timer_irq = 0.
//  sys_cnt: increments by 1 every clk and wraps modulo 2^SYS_W. A write to DIV (any wdata) clears it to 0.
//  Reads:
//   - DIV returns sys_cnt[15:8]. TIMA and TMA return their values.
//   - TAC returns {5'b11111, TAC[2:0]}.
//  Tick source:
//   - tap = sys_cnt bit 9/3/5/7 for TAC[1:0] = 00/01/10/11; tick_in = TAC[2] & tap.
//   - TIMA increments on a 1->0 transition of tick_in (registered previous value).
//   - Consequences: a DIV write while tap = 1, or a TAC write that drops tick_in from 1 to 0, produces one increment (hardware glitch, required).
//  FSM states RUN, OVF, RELOAD:
//   - RUN: a tick with TIMA = FF sets TIMA = 00, loads ovf_cnt = OVF_DELAY-1, and moves to OVF.
//   - OVF: ovf_cnt decrements each cycle. At 0, go to RELOAD.
//     A CPU write to TIMA in OVF stores wdata, cancels the reload and the IRQ, and returns to RUN.
//     Ticks in OVF increment TIMA normally.
//   - RELOAD (exactly one cycle): TIMA <= TMA, timer_irq = 1, then RUN.
//     A TIMA write in RELOAD is ignored.
//     A TMA write in RELOAD updates TMA, and TIMA takes the new wdata the same cycle.
//  Latency: IRQ asserts OVF_DELAY cycles after the overflowing tick edge. TIMA = TMA visible on the next read cycle.
//  Simultaneous events:
//   - CPU write to TIMA in RUN beats a same-cycle tick; the tick is lost.
//   - DIV write and tick evaluation use the pre-write tap for edge detection.
//  Width: all TIMA arithmetic is 8-bit modulo. Overflow is detected on FF -> 00 only.
//  Mid-operation reset: async clear from any state. No pending IRQ survives reset.
// STRUCTURE
//  Shared package gb_pkg gains:
//   - timer_reg_t enum {TMR_DIV, TMR_TIMA, TMR_TMA, TMR_TAC}
//   - tac_clk_t enum {TAC_4K, TAC_262K, TAC_65K, TAC_16K}
//   - timer_state_t enum {TMR_RUN, TMR_OVF, TMR_RELOAD}
//  One sub-module, timer_tick_gen: holds sys_cnt, the tap mux and the falling-edge detector, and outputs a one-cycle tick.
//  The top level holds the register file, the FSM and the bus read mux.
// TESTING
//  1. TAC = 3'b101, TIMA = 8'hFE, TMA = 8'h80; run 32 clk -> TIMA 00 for 4 clk, then 80, single timer_irq pulse.
//  2. TAC = 3'b100; read DIV after 2048 clk from reset -> 8'h08. TIMA = 8'h02 (one tick per 1024 clk).
//  3. Overflow, then write TIMA = 8'h33 two clk later -> TIMA stays 33, no timer_irq, FSM back in RUN.
//  4. Write TMA = 8'h55 during the RELOAD cycle -> TIMA = 55 and timer_irq still pulses once.
//  5. TAC = 3'b101, sys_cnt[3] = 1, write DIV -> TIMA increments by 1 and DIV reads 00.
//  6. Drop rst mid-OVF -> all registers 0, timer_irq 0, no IRQ after rst deasserts; TAC read returns 8'hF8.

Source files
------------

// File: rtl/gb_pkg.sv
// -----------------------------------------------------------------------------
// gb_pkg
//   Shared GameBoy definitions used by the timer block.
//   Contents:
//     timer_reg_t    - register offsets inside the FF04-FF07 window
//     tac_clk_t      - TAC[1:0] input clock selections
//     timer_state_t  - overflow/reload FSM states
//     TMR_BUS_IDLE   - read value when the timer is not selected
//     TMR_TAC_PAD    - constant upper bits returned on a TAC read
//     tac_tap_index  - maps a clock select to the system counter tap bit
// -----------------------------------------------------------------------------
package gb_pkg;

    typedef enum logic [1:0] {
        TMR_DIV  = 2'd0,
        TMR_TIMA = 2'd1,
        TMR_TMA  = 2'd2,
        TMR_TAC  = 2'd3
    } timer_reg_t;

    // Names give the resulting TIMA tick rate at a 4.194304 MHz clock.
    typedef enum logic [1:0] {
        TAC_4K   = 2'd0,
        TAC_262K = 2'd1,
        TAC_65K  = 2'd2,
        TAC_16K  = 2'd3
    } tac_clk_t;

    typedef enum logic [1:0] {
        TMR_RUN    = 2'd0,
        TMR_OVF    = 2'd1,
        TMR_RELOAD = 2'd2
    } timer_state_t;

    localparam logic [7:0] TMR_BUS_IDLE = 8'hFF;
    localparam logic [4:0] TMR_TAC_PAD  = 5'b11111;

    // System counter bit whose falling edge advances TIMA.
    function automatic int tac_tap_index(input tac_clk_t sel);
        int idx;
        case (sel)
            TAC_4K:   idx = 9;
            TAC_262K: idx = 3;
            TAC_65K:  idx = 5;
            TAC_16K:  idx = 7;
            default:  idx = 9;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/timer_unit_tick_gen.sv
// -----------------------------------------------------------------------------
// timer_tick_gen
//   Free-running system counter (DIV source), TAC tap selection and the
//   falling-edge detector that produces the TIMA increment strobe.
//   Ports:
//     clk_i       system clock, rising edge
//     rst_ni      asynchronous active-low reset
//     div_clr_i   clear the system counter (bus write to DIV)
//     tac_en_i    TAC[2], timer enable
//     tac_clk_i   TAC[1:0], tap selection
//     tick_o      one-cycle strobe: tick_in fell since the previous cycle
//     div_o       upper 8 bits of the system counter
// -----------------------------------------------------------------------------
module timer_tick_gen
    import gb_pkg::*;
#(
    parameter int SYS_W = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       div_clr_i,
    input  logic       tac_en_i,
    input  tac_clk_t   tac_clk_i,
    output logic       tick_o,
    output logic [7:0] div_o
);

    logic [SYS_W-1:0] sys_cnt_q, sys_cnt_d;
    logic             tick_prev_q, tick_prev_d;
    logic             tap;
    logic             tick_in;

    // Tap comes from the registered counter, so a DIV write in this cycle
    // does not disturb the current edge evaluation; the cleared counter is
    // seen next cycle, which is what yields the DIV-write glitch tick.
    always_comb begin
        case (tac_clk_i)
            TAC_4K:   tap = sys_cnt_q[9];
            TAC_262K: tap = sys_cnt_q[3];
            TAC_65K:  tap = sys_cnt_q[5];
            TAC_16K:  tap = sys_cnt_q[7];
            default:  tap = sys_cnt_q[9];
        endcase
    end

    assign tick_in = tac_en_i & tap;

    // A TAC change that drops tick_in also reads as a falling edge here.
    assign tick_o = tick_prev_q & ~tick_in;

    always_comb begin
        sys_cnt_d   = div_clr_i ? '0 : sys_cnt_q + 1'b1;
        tick_prev_d = tick_in;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sys_cnt_q   <= '0;
            tick_prev_q <= 1'b0;
        end else begin
            sys_cnt_q   <= sys_cnt_d;
            tick_prev_q <= tick_prev_d;
        end
    end

    assign div_o = sys_cnt_q[SYS_W-1 -: 8];

endmodule

// File: rtl/timer_unit.sv
// -----------------------------------------------------------------------------
// timer_unit
//   GameBoy DIV/TIMA/TMA/TAC timer mapped at FF04-FF07.
//   Holds the register file, the overflow/reload FSM and the bus read mux;
//   counter and tick generation live in timer_tick_gen.
//   Ports:
//     clk        system clock (one T-cycle), rising edge
//     rst        asynchronous active-low reset
//     sel        bus access targets FF04-FF07 this cycle
//     addr       register offset (DIV, TIMA, TMA, TAC)
//     we         write strobe, qualified by sel
//     wdata      write data
//     rdata      combinational read data, 8'hFF when not selected
//     timer_irq  one-cycle interrupt request (IF bit 2)
//     state_dbg  current FSM state, for observation only
//   Bus handshake: there is no stall. A cycle with sel=1 is a complete access;
//   with we=1 the write commits on that rising edge, with we=0 rdata is valid
//   combinationally during that cycle.
// -----------------------------------------------------------------------------
module timer_unit
    import gb_pkg::*;
#(
    parameter int SYS_W     = 16,
    parameter int OVF_DELAY = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sel,
    input  logic [1:0]   addr,
    input  logic         we,
    input  logic [7:0]   wdata,
    output logic [7:0]   rdata,
    output logic         timer_irq,
    output timer_state_t state_dbg
);

    localparam int OVF_CNT_W = (OVF_DELAY > 1) ? $clog2(OVF_DELAY) : 1;
    localparam logic [OVF_CNT_W-1:0] OVF_LOAD = OVF_CNT_W'(OVF_DELAY - 1);

    timer_state_t         state_q, state_d;
    logic [7:0]           tima_q, tima_d;
    logic [7:0]           tma_q, tma_d;
    logic [2:0]           tac_q, tac_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    timer_reg_t reg_sel;
    logic       wr_div, wr_tima, wr_tma, wr_tac;
    logic       tick;
    logic [7:0] div_val;

    // -------------------------------------------------------------------------
    // Bus write decode
    // -------------------------------------------------------------------------
    assign reg_sel = timer_reg_t'(addr);
    assign wr_div  = sel & we & (reg_sel == TMR_DIV);
    assign wr_tima = sel & we & (reg_sel == TMR_TIMA);
    assign wr_tma  = sel & we & (reg_sel == TMR_TMA);
    assign wr_tac  = sel & we & (reg_sel == TMR_TAC);

    // -------------------------------------------------------------------------
    // Tick source
    // -------------------------------------------------------------------------
    timer_tick_gen #(
        .SYS_W (SYS_W)
    ) u_tick_gen (
        .clk_i     (clk),
        .rst_ni    (rst),
        .div_clr_i (wr_div),
        .tac_en_i  (tac_q[2]),
        .tac_clk_i (tac_clk_t'(tac_q[1:0])),
        .tick_o    (tick),
        .div_o     (div_val)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TMR_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            TMR_RUN: begin
                // A TIMA write swallows a same-cycle tick, so it also
                // prevents the overflow.
                if (!wr_tima && tick && (tima_q == 8'hFF)) begin
                    state_d = TMR_OVF;
                end
            end
            TMR_OVF: begin
                if (wr_tima) begin
                    state_d = TMR_RUN;
                end else if (ovf_cnt_q == '0) begin
                    state_d = TMR_RELOAD;
                end
            end
            TMR_RELOAD: begin
                state_d = TMR_RUN;
            end
            default: begin
                state_d = TMR_RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        timer_irq = (state_q == TMR_RELOAD);
        state_dbg = state_q;
    end

    // -------------------------------------------------------------------------
    // Register file next-state
    // -------------------------------------------------------------------------
    always_comb begin
        tima_d    = tima_q;
        tma_d     = tma_q;
        tac_d     = tac_q;
        ovf_cnt_d = ovf_cnt_q;

        if (wr_tma) begin
            tma_d = wdata;
        end
        if (wr_tac) begin
            tac_d = wdata[2:0];
        end

        case (state_q)
            TMR_RUN: begin
                if (wr_tima) begin
                    tima_d = wdata;
                end else if (tick) begin
                    if (tima_q == 8'hFF) begin
                        tima_d    = 8'h00;
                        ovf_cnt_d = OVF_LOAD;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            TMR_OVF: begin
                if (wr_tima) begin
                    tima_d = wdata;
                end else if (tick) begin
                    tima_d = tima_q + 8'd1;
                end
                if (ovf_cnt_q != '0) begin
                    ovf_cnt_d = ovf_cnt_q - 1'b1;
                end
            end
            TMR_RELOAD: begin
                // TIMA writes are ignored here; a TMA write lands in TIMA
                // too, as the reload sees the new value.
                tima_d = wr_tma ? wdata : tma_q;
            end
            default: begin
                tima_d = tima_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tima_q    <= 8'h00;
            tma_q     <= 8'h00;
            tac_q     <= 3'b000;
            ovf_cnt_q <= '0;
        end else begin
            tima_q    <= tima_d;
            tma_q     <= tma_d;
            tac_q     <= tac_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Bus read mux
    // -------------------------------------------------------------------------
    always_comb begin
        rdata = TMR_BUS_IDLE;
        if (sel) begin
            case (reg_sel)
                TMR_DIV:  rdata = div_val;
                TMR_TIMA: rdata = tima_q;
                TMR_TMA:  rdata = tma_q;
                TMR_TAC:  rdata = {TMR_TAC_PAD, tac_q};
                default:  rdata = TMR_BUS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_unit.sv
// -----------------------------------------------------------------------------
// tb_timer_unit
//   Directed bench for timer_unit. The edge counter "edges" counts rising
//   edges since reset release, so with no DIV writes it equals sys_cnt.
//   Inputs are driven 1 time unit after a rising edge and outputs sampled
//   there too, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_timer_unit;
    import gb_pkg::*;

    logic         clk;
    logic         rst;
    logic         sel;
    logic [1:0]   addr;
    logic         we;
    logic [7:0]   wdata;
    logic [7:0]   rdata;
    logic         timer_irq;
    timer_state_t state_dbg;

    int errors = 0;
    int checks = 0;
    int edges;
    int irq_cnt = 0;
    int irq_base;

    timer_unit #(
        .SYS_W     (16),
        .OVF_DELAY (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .addr      (addr),
        .we        (we),
        .wdata     (wdata),
        .rdata     (rdata),
        .timer_irq (timer_irq),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset bookkeeping ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    always @(negedge clk) begin
        if (timer_irq) irq_cnt <= irq_cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input timer_reg_t r, input logic [7:0] exp);
        logic [7:0] v;
        sel  = 1'b1;
        we   = 1'b0;
        addr = r;
        #1;
        v   = rdata;
        sel = 1'b0;
        chk(tag, v, exp);
    endtask

    // ---------------- drivers ----------------
    task automatic bus_write(input timer_reg_t r, input logic [7:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = r;
        wdata = d;
        @(posedge clk);
        #1;
        sel   = 1'b0;
        we    = 1'b0;
        wdata = 8'h00;
    endtask

    task automatic wait_edge(input int e);
        int guard = 0;
        while (edges < e) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 20000) begin
                errors++;
                $display("FAIL wait_edge observed=%0d expected=%0d", edges, e);
                $fatal(1, "edge wait expired");
            end
        end
    endtask

    task automatic do_reset();
        sel   = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 8'h00;
        rst   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // TMA=80 at edge 1, TIMA=FE at edge 2, TAC=101 at edge 3. Bit 3 falls at
    // counts 16 and 32, committing at edges 17 (FF) and 33 (overflow).
    task automatic ovf_setup();
        do_reset();
        bus_write(TMR_TMA, 8'h80);
        bus_write(TMR_TIMA, 8'hFE);
        bus_write(TMR_TAC, 8'h05);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        do_reset();

        // Reset state
        chk_rd("rst_div", TMR_DIV, 8'h00);
        chk_rd("rst_tima", TMR_TIMA, 8'h00);
        chk_rd("rst_tma", TMR_TMA, 8'h00);
        chk_rd("rst_tac", TMR_TAC, 8'hF8);
        chk("rst_irq", 8'(timer_irq), 8'h00);
        chk("rst_state", 8'(state_dbg), 8'(TMR_RUN));
        sel = 1'b0;
        #1;
        chk("idle_rdata", rdata, 8'hFF);

        // 1. Overflow, 4-cycle zero window, reload, single IRQ
        ovf_setup();
        irq_base = irq_cnt;
        wait_edge(17);
        chk_rd("t1_tima_ff", TMR_TIMA, 8'hFF);
        wait_edge(32);
        chk_rd("t1_pre_ovf", TMR_TIMA, 8'hFF);
        wait_edge(33);
        chk_rd("t1_ovf_tima", TMR_TIMA, 8'h00);
        chk("t1_ovf_state", 8'(state_dbg), 8'(TMR_OVF));
        chk("t1_ovf_irq", 8'(timer_irq), 8'h00);
        wait_edge(36);
        chk_rd("t1_ovf_last", TMR_TIMA, 8'h00);
        chk("t1_ovf_last_irq", 8'(timer_irq), 8'h00);
        wait_edge(37);
        chk("t1_reload_irq", 8'(timer_irq), 8'h01);
        chk("t1_reload_state", 8'(state_dbg), 8'(TMR_RELOAD));
        wait_edge(38);
        chk_rd("t1_tima_tma", TMR_TIMA, 8'h80);
        chk("t1_post_irq", 8'(timer_irq), 8'h00);
        chk("t1_post_state", 8'(state_dbg), 8'(TMR_RUN));
        wait_edge(50);
        chk_rd("t1_next_tick", TMR_TIMA, 8'h81);
        chk("t1_irq_pulses", 8'(irq_cnt - irq_base), 8'h01);

        // 2. Free-running DIV and 4 KiHz ticks (falls at 0x400 and 0x800
        //    commit on the following edge)
        do_reset();
        bus_write(TMR_TAC, 8'h04);
        wait_edge(1024);
        chk_rd("t2_tima_1024", TMR_TIMA, 8'h00);
        wait_edge(1025);
        chk_rd("t2_tima_1025", TMR_TIMA, 8'h01);
        wait_edge(2048);
        chk_rd("t2_div", TMR_DIV, 8'h08);
        wait_edge(2049);
        chk_rd("t2_tima", TMR_TIMA, 8'h02);

        // 3. TIMA write two cycles into OVF cancels the reload and IRQ
        ovf_setup();
        irq_base = irq_cnt;
        wait_edge(34);
        bus_write(TMR_TIMA, 8'h33);
        chk_rd("t3_tima", TMR_TIMA, 8'h33);
        chk("t3_state", 8'(state_dbg), 8'(TMR_RUN));
        wait_edge(45);
        chk_rd("t3_tima_hold", TMR_TIMA, 8'h33);
        chk("t3_no_irq", 8'(irq_cnt - irq_base), 8'h00);

        // 4. TMA write during RELOAD goes straight to TIMA
        ovf_setup();
        irq_base = irq_cnt;
        wait_edge(37);
        chk("t4_reload_irq", 8'(timer_irq), 8'h01);
        bus_write(TMR_TMA, 8'h55);
        chk_rd("t4_tima", TMR_TIMA, 8'h55);
        chk_rd("t4_tma", TMR_TMA, 8'h55);
        wait_edge(45);
        chk("t4_irq_pulses", 8'(irq_cnt - irq_base), 8'h01);

        // 4b. TIMA write during RELOAD is ignored
        ovf_setup();
        wait_edge(37);
        bus_write(TMR_TIMA, 8'h77);
        chk_rd("t4b_tima", TMR_TIMA, 8'h80);

        // 5. DIV write while bit 3 is high gives one glitch tick; later a
        //    TIMA write beats a same-cycle tick
        do_reset();
        bus_write(TMR_TAC, 8'h05);
        wait_edge(8);
        bus_write(TMR_DIV, 8'hAB);
        chk_rd("t5_div", TMR_DIV, 8'h00);
        chk_rd("t5_tima_pre", TMR_TIMA, 8'h00);
        wait_edge(10);
        chk_rd("t5_tima_glitch", TMR_TIMA, 8'h01);
        // counter restarted at edge 9, so count 16 is reached at edge 25
        wait_edge(25);
        bus_write(TMR_TIMA, 8'h40);
        chk_rd("t5_wr_beats_tick", TMR_TIMA, 8'h40);
        wait_edge(30);
        chk_rd("t5_tima_hold", TMR_TIMA, 8'h40);

        // 7. TAC write that drops tick_in gives one glitch tick
        do_reset();
        bus_write(TMR_TAC, 8'h05);
        wait_edge(8);
        bus_write(TMR_TAC, 8'h00);
        wait_edge(10);
        chk_rd("t7_tac_glitch", TMR_TIMA, 8'h01);
        chk_rd("t7_tac", TMR_TAC, 8'hF8);

        // 6. Reset asserted mid-OVF clears everything, no late IRQ
        ovf_setup();
        wait_edge(35);
        chk("t6_in_ovf", 8'(state_dbg), 8'(TMR_OVF));
        irq_base = irq_cnt;
        rst = 1'b0;
        #1;
        chk_rd("t6_div", TMR_DIV, 8'h00);
        chk_rd("t6_tima", TMR_TIMA, 8'h00);
        chk_rd("t6_tma", TMR_TMA, 8'h00);
        chk_rd("t6_tac", TMR_TAC, 8'hF8);
        chk("t6_irq", 8'(timer_irq), 8'h00);
        chk("t6_state", 8'(state_dbg), 8'(TMR_RUN));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        wait_edge(20);
        chk("t6_no_late_irq", 8'(irq_cnt - irq_base), 8'h00);
        chk_rd("t6_tima_after", TMR_TIMA, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
